spi_ss_ctrl: RTL and testbench

SPI_SS_CTRL -- requirements
Module: spi_ss_ctrl

---
 rtl/spi_ss_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_spi_ss_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ss_ctrl.sv
// spi_ss_ctrl: SPI slave-select and frame-timing controller.
// Drives one active-low select for FRAME_BITS SCK periods per send request,
// then pulses receive_data_o. Retrigger, abort on disable and an
// out-of-range select error are handled in the single-process FSM.
// Optional feature macro: SPI_SS_GUARD_EN adds a HOLD guard interval of
// half an SCK period (all selects high) after every completed frame, with
// one pending request captured during HOLD.
module spi_ss_ctrl #(
    parameter int NUM_SS     = 4,
    parameter int FRAME_BITS = 8,
    parameter int CNT_W      = 16,
    localparam int SEL_W     = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              PCLK,
    input  logic              PRESET_n,
    input  logic [1:0]        spi_mode_i,
    input  logic              mstr_i,
    input  logic              spiswai_i,
    input  logic              send_data_i,
    input  logic [SEL_W-1:0]  ss_sel_i,
    input  logic [11:0]       BaudRateDivisor_i,
    output logic [NUM_SS-1:0] ss_n_o,
    output logic              receive_data_o,
    output logic              tip_o,
    output logic              sel_err_o
);

    // Product of half (<= 2047), 2 and FRAME_BITS (<= 32) fits in 18 bits.
    localparam int PROD_W = 18;
    localparam logic [SEL_W:0] NUM_SS_L = (SEL_W + 1)'(NUM_SS);

`ifdef SPI_SS_GUARD_EN
    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_HOLD} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE} state_t;
`endif

    // Frame length in PCLK cycles: half*2*FRAME_BITS, half forced to at
    // least 1, saturated to the counter width.
    function automatic logic [CNT_W-1:0] calc_target(input logic [11:0] div);
        logic [11:0]       h;
        logic [PROD_W-1:0] p;
        h = div >> 1;
        if (h == 12'd0) h = 12'd1;
        p = PROD_W'(h) * PROD_W'(2 * FRAME_BITS);
        if ((p >> CNT_W) != '0) return '1;
        return CNT_W'(p);
    endfunction

    // Active-low one-cold select pattern for slave index s.
    function automatic logic [NUM_SS-1:0] sel_mask(input logic [SEL_W-1:0] s);
        logic [NUM_SS-1:0] m;
        for (int i = 0; i < NUM_SS; i++) m[i] = (SEL_W'(i) != s);
        return m;
    endfunction

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [SEL_W-1:0]    r_sel;
    logic [NUM_SS-1:0]   r_ss_n;
    logic                r_rx;
    logic                r_err;

    logic                w_en;
    logic                w_sel_ok;
    logic [CNT_W-1:0]    w_target;
    logic                w_last;

    assign w_en     = mstr_i & ((spi_mode_i == 2'b00) | ((spi_mode_i == 2'b01) & ~spiswai_i));
    assign w_sel_ok = ({1'b0, ss_sel_i} < NUM_SS_L);
    assign w_target = calc_target(BaudRateDivisor_i);
    // Target is re-evaluated every cycle, so a shrinking divisor ends the
    // frame on the next edge once the count has already passed it.
    assign w_last   = (r_cnt >= (w_target - CNT_W'(1)));

`ifdef SPI_SS_GUARD_EN
    logic [11:0]         w_half;
    logic [11:0]         r_hold;
    logic                r_pend;
    logic [SEL_W-1:0]    r_pend_sel;

    assign w_half = (BaudRateDivisor_i[11:1] == 11'd0) ? 12'd1 : {1'b0, BaudRateDivisor_i[11:1]};
`endif

    // Frame FSM with registered select, completion and error outputs.
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_sel      <= '0;
            r_ss_n     <= '1;
            r_rx       <= 1'b0;
            r_err      <= 1'b0;
`ifdef SPI_SS_GUARD_EN
            r_hold     <= '0;
            r_pend     <= 1'b0;
            r_pend_sel <= '0;
`endif
        end else begin
            r_rx  <= 1'b0;
            r_err <= 1'b0;
            if (!w_en) begin
                // Disable aborts silently from any state.
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_ss_n  <= '1;
`ifdef SPI_SS_GUARD_EN
                r_hold  <= '0;
                r_pend  <= 1'b0;
`endif
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (send_data_i) begin
                            if (w_sel_ok) begin
                                r_sel   <= ss_sel_i;
                                r_cnt   <= '0;
                                r_ss_n  <= sel_mask(ss_sel_i);
                                r_state <= ST_ACTIVE;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                    ST_ACTIVE: begin
                        if (send_data_i) begin
                            // Retrigger beats completion; selected slave kept.
                            r_cnt  <= '0;
                            r_ss_n <= sel_mask(r_sel);
                        end else if (w_last) begin
                            r_cnt   <= '0;
                            r_ss_n  <= '1;
                            r_rx    <= 1'b1;
`ifdef SPI_SS_GUARD_EN
                            r_state <= ST_HOLD;
                            r_hold  <= '0;
                            r_pend  <= 1'b0;
`else
                            r_state <= ST_IDLE;
`endif
                        end else begin
                            r_cnt  <= r_cnt + CNT_W'(1);
                            r_ss_n <= sel_mask(r_sel);
                        end
                    end
`ifdef SPI_SS_GUARD_EN
                    ST_HOLD: begin
                        if (r_hold >= (w_half - 12'd1)) begin
                            r_hold <= '0;
                            r_pend <= 1'b0;
                            if (send_data_i && w_sel_ok) begin
                                r_sel   <= ss_sel_i;
                                r_cnt   <= '0;
                                r_ss_n  <= sel_mask(ss_sel_i);
                                r_state <= ST_ACTIVE;
                            end else begin
                                if (send_data_i) r_err <= 1'b1;
                                if (r_pend) begin
                                    r_sel   <= r_pend_sel;
                                    r_cnt   <= '0;
                                    r_ss_n  <= sel_mask(r_pend_sel);
                                    r_state <= ST_ACTIVE;
                                end else begin
                                    r_state <= ST_IDLE;
                                end
                            end
                        end else begin
                            r_hold <= r_hold + 12'd1;
                            if (send_data_i) begin
                                if (w_sel_ok) begin
                                    r_pend     <= 1'b1;
                                    r_pend_sel <= ss_sel_i;
                                end else begin
                                    r_err <= 1'b1;
                                end
                            end
                        end
                    end
`endif
                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_ss_n  <= '1;
                    end
                endcase
            end
        end
    end

    assign ss_n_o         = r_ss_n;
    assign receive_data_o = r_rx;
    assign sel_err_o      = r_err;
    assign tip_o          = ~(&r_ss_n);

endmodule

// File: tb/tb_spi_ss_ctrl.sv
// Directed bench for spi_ss_ctrl with a frame scoreboard. A second
// instance with NUM_SS=5 covers the out-of-range select error, since a
// 2-bit select on a 4-slave build cannot express an illegal index.
`timescale 1ns/1ps
module tb_spi_ss_ctrl;

    logic        PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    logic        PRESET_n;
    logic [1:0]  spi_mode;
    logic        mstr, spiswai, send, send5;
    logic [1:0]  sel;
    logic [2:0]  sel5;
    logic [11:0] div;
    logic [3:0]  ss_n;
    logic        rx, tip, err;
    logic [4:0]  ss_n5;
    logic        rx5, tip5, err5;

    typedef struct {
        int         len;
        logic [3:0] pat;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_pass   = 0;
    int          n_total  = 0;
    int          rx_count = 0;
    int          low_cnt  = 0;
    logic [3:0]  low_pat  = 4'hF;

    spi_ss_ctrl #(.NUM_SS(4), .FRAME_BITS(8), .CNT_W(16)) u_dut (
        .PCLK              (PCLK),
        .PRESET_n          (PRESET_n),
        .spi_mode_i        (spi_mode),
        .mstr_i            (mstr),
        .spiswai_i         (spiswai),
        .send_data_i       (send),
        .ss_sel_i          (sel),
        .BaudRateDivisor_i (div),
        .ss_n_o            (ss_n),
        .receive_data_o    (rx),
        .tip_o             (tip),
        .sel_err_o         (err)
    );

    spi_ss_ctrl #(.NUM_SS(5), .FRAME_BITS(8), .CNT_W(16)) u_dut5 (
        .PCLK              (PCLK),
        .PRESET_n          (PRESET_n),
        .spi_mode_i        (spi_mode),
        .mstr_i            (mstr),
        .spiswai_i         (spiswai),
        .send_data_i       (send5),
        .ss_sel_i          (sel5),
        .BaudRateDivisor_i (div),
        .ss_n_o            (ss_n5),
        .receive_data_o    (rx5),
        .tip_o             (tip5),
        .sel_err_o         (err5)
    );

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_total++;
        assert (obs === exp_v) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    task automatic send_frame(input logic [1:0] s);
        sel  = s;
        send = 1'b1;
        tick(1);
        send = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i;
        i = 0;
        while ((sb.size() != 0 || tip) && i < budget) begin
            tick(1);
            i++;
        end
        chk("drain", sb.size(), 0);
        tick(4);
    endtask

    // Measure each select-low run and score it when the completion pulse arrives.
    always @(negedge PCLK) begin
        if (!PRESET_n) begin
            low_cnt = 0;
        end else if (rx) begin
            rx_count++;
            mon_e = '{len: 0, pat: 4'hF};
            if (sb.size() != 0) mon_e = sb.pop_front();
            chk("frame_len", low_cnt, mon_e.len);
            chk("frame_sel", int'(low_pat), int'(mon_e.pat));
            low_cnt = 0;
        end else if (ss_n != 4'hF) begin
            low_cnt++;
            low_pat = ss_n;
        end else begin
            low_cnt = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        PRESET_n = 1'b0;
        spi_mode = 2'b00;
        mstr     = 1'b1;
        spiswai  = 1'b0;
        send     = 1'b0;
        send5    = 1'b0;
        sel      = 2'd0;
        sel5     = 3'd0;
        div      = 12'd4;

        // Reset state
        #12;
        chk("rst_ss_n", int'(ss_n), 4'hF);
        chk("rst_rx", int'(rx), 0);
        chk("rst_tip", int'(tip), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_ss_n5", int'(ss_n5), 5'h1F);
        @(posedge PCLK);
        #1;
        PRESET_n = 1'b1;
        tick(2);

        // Divisor 4, slave 2: 32-cycle frame
        sb.push_back('{len: 32, pat: 4'b1011});
        send_frame(2'd2);
        chk("t1_ss_n", int'(ss_n), 4'b1011);
        chk("t1_tip", int'(tip), 1);
        wait_done(200);
        chk("t1_rx_count", rx_count, 1);

        // Divisor 0: half forced to 1, 16-cycle frame
        div = 12'd0;
        sb.push_back('{len: 16, pat: 4'b1110});
        send_frame(2'd0);
        chk("t2_ss_n", int'(ss_n), 4'b1110);
        wait_done(200);
        chk("t2_rx_count", rx_count, 2);
        div = 12'd4;

        // Retrigger at count 10: 43 cycles low, new select index ignored
        sb.push_back('{len: 43, pat: 4'b1101});
        send_frame(2'd1);
        tick(10);
        send_frame(2'd3);
        chk("t3_retrig_ss_n", int'(ss_n), 4'b1101);
        chk("t3_retrig_rx", int'(rx), 0);
        wait_done(200);
        chk("t3_rx_count", rx_count, 3);

        // Retrigger on the final count: retrigger wins, 64 cycles low
        sb.push_back('{len: 64, pat: 4'b0111});
        send_frame(2'd3);
        tick(31);
        send_frame(2'd0);
        chk("t4_last_ss_n", int'(ss_n), 4'b0111);
        chk("t4_last_rx", int'(rx), 0);
        wait_done(200);
        chk("t4_rx_count", rx_count, 4);

        // Wait mode with stop-in-wait raised at count 5: silent abort
        spi_mode = 2'b01;
        send_frame(2'd3);
        chk("t5_wait_run_ss_n", int'(ss_n), 4'b0111);
        tick(5);
        spiswai = 1'b1;
        tick(1);
        chk("t5_abort_ss_n", int'(ss_n), 4'hF);
        chk("t5_abort_tip", int'(tip), 0);
        chk("t5_abort_rx", int'(rx), 0);
        send_frame(2'd0);
        chk("t5_send_dis_ss_n", int'(ss_n), 4'hF);
        spi_mode = 2'b10;
        spiswai  = 1'b0;
        send_frame(2'd1);
        chk("t5_stop_ss_n", int'(ss_n), 4'hF);
        spi_mode = 2'b00;
        tick(2);
        chk("t5_rx_count", rx_count, 4);

        // Select index out of range on the 5-slave instance
        sel5  = 3'd5;
        send5 = 1'b1;
        tick(1);
        send5 = 1'b0;
        chk("t6_err_pulse", int'(err5), 1);
        chk("t6_err_ss_n5", int'(ss_n5), 5'h1F);
        chk("t6_err_tip5", int'(tip5), 0);
        tick(1);
        chk("t6_err_clear", int'(err5), 0);
        sel5  = 3'd4;
        send5 = 1'b1;
        tick(1);
        send5 = 1'b0;
        chk("t6_top_ss_n5", int'(ss_n5), 5'b01111);
        chk("t6_top_err", int'(err5), 0);

        // Asynchronous reset at count 20, no pulse, then normal frame
        send_frame(2'd0);
        tick(20);
        PRESET_n = 1'b0;
        #1;
        chk("t7_rst_ss_n", int'(ss_n), 4'hF);
        chk("t7_rst_tip", int'(tip), 0);
        chk("t7_rst_rx", int'(rx), 0);
        #10;
        PRESET_n = 1'b1;
        tick(3);
        chk("t7_rst_rx_count", rx_count, 4);
        sb.push_back('{len: 32, pat: 4'b1011});
        send_frame(2'd2);
        chk("t7_after_ss_n", int'(ss_n), 4'b1011);
        wait_done(200);
        chk("t7_rx_count", rx_count, 5);

        // Back-to-back request right after completion
        sb.push_back('{len: 32, pat: 4'b1011});
        sb.push_back('{len: 32, pat: 4'b1101});
        send_frame(2'd2);
        tick(32);
        chk("t8_end_rx", int'(rx), 1);
        chk("t8_end_ss_n", int'(ss_n), 4'hF);
`ifdef SPI_SS_GUARD_EN
        send_frame(2'd1);
        chk("t8_hold_ss_n", int'(ss_n), 4'hF);
        tick(1);
        chk("t8_pend_ss_n", int'(ss_n), 4'b1101);
`else
        send_frame(2'd1);
        chk("t8_next_ss_n", int'(ss_n), 4'b1101);
`endif
        wait_done(200);
        chk("t8_rx_count", rx_count, 7);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
